// File: rtl/display_decoder.sv
// Loopback checker for the three-digit 7-segment display path.
// It decodes the three active-low segment patterns to BCD and checks the
// leading-blank rules. The BCD value is then turned into binary by reverse
// double-dabble, one bit per clock, under a start/busy/done handshake.
module display_decoder (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [6:0] digito0,
  input  logic [6:0] digito1,
  input  logic [6:0] digito2,
  output logic [9:0] valor,
  output logic       busy,
  output logic       done,
  output logic       erro
);

  localparam int unsigned SEG_W = 7;
  localparam int unsigned DIG_W = 4;
  localparam int unsigned BCD_W = 3 * DIG_W;
  localparam int unsigned BIN_W = 10;
  localparam int unsigned CNT_W = 4;
  localparam int unsigned ACC_W = BCD_W + BIN_W;

  localparam logic [CNT_W-1:0] LAST_SHIFT = CNT_W'(BIN_W - 1);

  // Active-low patterns, bit6..bit0 = g..a.
  localparam logic [SEG_W-1:0] SEG_0     = 7'b1000000;
  localparam logic [SEG_W-1:0] SEG_1     = 7'b1111001;
  localparam logic [SEG_W-1:0] SEG_2     = 7'b0100100;
  localparam logic [SEG_W-1:0] SEG_3     = 7'b0110000;
  localparam logic [SEG_W-1:0] SEG_4     = 7'b0011001;
  localparam logic [SEG_W-1:0] SEG_5     = 7'b0010010;
  localparam logic [SEG_W-1:0] SEG_6     = 7'b0000010;
  localparam logic [SEG_W-1:0] SEG_7     = 7'b1111000;
  localparam logic [SEG_W-1:0] SEG_8     = 7'b0000000;
  localparam logic [SEG_W-1:0] SEG_9     = 7'b0010000;
  localparam logic [SEG_W-1:0] SEG_BLANK = 7'b1111111;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DECODE = 2'd1,
    SHIFT  = 2'd2,
    DONE   = 2'd3
  } state_t;

  typedef struct packed {
    logic             valid;
    logic             blank;
    logic [DIG_W-1:0] digit;
  } seg_dec_t;

  // Map one segment pattern to a digit. A blank counts as digit 0 but is flagged.
  function automatic seg_dec_t seg_decode(input logic [SEG_W-1:0] pat);
    seg_dec_t r;
    r.valid = 1'b1;
    r.blank = 1'b0;
    r.digit = '0;
    case (pat)
      SEG_0:     r.digit = DIG_W'(0);
      SEG_1:     r.digit = DIG_W'(1);
      SEG_2:     r.digit = DIG_W'(2);
      SEG_3:     r.digit = DIG_W'(3);
      SEG_4:     r.digit = DIG_W'(4);
      SEG_5:     r.digit = DIG_W'(5);
      SEG_6:     r.digit = DIG_W'(6);
      SEG_7:     r.digit = DIG_W'(7);
      SEG_8:     r.digit = DIG_W'(8);
      SEG_9:     r.digit = DIG_W'(9);
      SEG_BLANK: r.blank = 1'b1;
      default:   r.valid = 1'b0;
    endcase
    return r;
  endfunction

  // Undo the +3 correction of double-dabble: a nibble >= 8 after the shift gets 3 taken off.
  function automatic logic [DIG_W-1:0] nibble_adjust(input logic [DIG_W-1:0] nib);
    return (nib >= DIG_W'(8)) ? nib - DIG_W'(3) : nib;
  endfunction

  state_t state, state_next;

  logic [SEG_W-1:0] cap0, cap1, cap2;
  logic [BCD_W-1:0] bcd;
  logic [BIN_W-1:0] bin;
  logic [CNT_W-1:0] cnt;

  seg_dec_t         dec0_c, dec1_c, dec2_c;
  logic             pattern_err_c, blank_err_c, decode_err_c;
  logic [ACC_W-1:0] shifted_c;
  logic [BCD_W-1:0] shift_bcd_c;
  logic [BIN_W-1:0] shift_bin_c;
  logic             last_shift_c;

  // Decode the captured patterns and evaluate the leading-blank rules.
  always_comb begin
    dec0_c        = seg_decode(cap0);
    dec1_c        = seg_decode(cap1);
    dec2_c        = seg_decode(cap2);
    pattern_err_c = !dec0_c.valid || !dec1_c.valid || !dec2_c.valid;
    // Ones may never be blank; tens may be blank only under a blank hundreds.
    blank_err_c   = dec0_c.blank || (dec1_c.blank && !dec2_c.blank);
    decode_err_c  = pattern_err_c || blank_err_c;
  end

  // One reverse double-dabble step: shift right, then correct every BCD nibble.
  always_comb begin
    shifted_c          = {bcd, bin} >> 1;
    shift_bin_c        = shifted_c[BIN_W-1:0];
    shift_bcd_c        = shifted_c[ACC_W-1:BIN_W];
    shift_bcd_c[3:0]   = nibble_adjust(shifted_c[BIN_W+3:BIN_W]);
    shift_bcd_c[7:4]   = nibble_adjust(shifted_c[BIN_W+7:BIN_W+4]);
    shift_bcd_c[11:8]  = nibble_adjust(shifted_c[BIN_W+11:BIN_W+8]);
    last_shift_c       = (cnt == LAST_SHIFT);
  end

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // Next-state logic.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = DECODE;
      DECODE:  state_next = decode_err_c ? DONE : SHIFT;
      SHIFT:   if (last_shift_c) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Datapath: pattern capture, BCD/binary shift register, counter and result.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cap0  <= '0;
      cap1  <= '0;
      cap2  <= '0;
      bcd   <= '0;
      bin   <= '0;
      cnt   <= '0;
      valor <= '0;
      erro  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            cap0 <= digito0;
            cap1 <= digito1;
            cap2 <= digito2;
          end
        end
        DECODE: begin
          if (decode_err_c) begin
            valor <= '0;
            erro  <= 1'b1;
          end else begin
            bcd <= {dec2_c.digit, dec1_c.digit, dec0_c.digit};
            bin <= '0;
            cnt <= '0;
          end
        end
        SHIFT: begin
          bcd <= shift_bcd_c;
          bin <= shift_bin_c;
          cnt <= cnt + CNT_W'(1);
          if (last_shift_c) begin
            valor <= shift_bin_c;
            erro  <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  // Handshake outputs, registered from the next state so they line up with it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      busy <= 1'b0;
      done <= 1'b0;
    end else begin
      busy <= (state_next == DECODE) || (state_next == SHIFT);
      done <= (state_next == DONE);
    end
  end

endmodule

// File: tb/tb_display_decoder.sv
// Directed bench for display_decoder: a table of conversions plus hand-written
// reset-abort and back-to-back start sequences.
module tb_display_decoder;

  localparam logic [6:0] S0 = 7'b1000000;
  localparam logic [6:0] S1 = 7'b1111001;
  localparam logic [6:0] S2 = 7'b0100100;
  localparam logic [6:0] S3 = 7'b0110000;
  localparam logic [6:0] S4 = 7'b0011001;
  localparam logic [6:0] S5 = 7'b0010010;
  localparam logic [6:0] S6 = 7'b0000010;
  localparam logic [6:0] S7 = 7'b1111000;
  localparam logic [6:0] S8 = 7'b0000000;
  localparam logic [6:0] S9 = 7'b0010000;
  localparam logic [6:0] SB = 7'b1111111;
  localparam logic [6:0] SX = 7'b0101010;

  localparam int VALID_EDGE = 11;
  localparam int ERROR_EDGE = 1;
  localparam int NVEC = 12;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic [6:0] digito0 = SB;
  logic [6:0] digito1 = SB;
  logic [6:0] digito2 = SB;
  logic [9:0] valor;
  logic       busy, done, erro;

  int tests = 0;
  int fails = 0;

  typedef struct {
    logic [6:0] d2;
    logic [6:0] d1;
    logic [6:0] d0;
    logic [9:0] v;
    logic       e;
    int         edge_idx;
  } vec_t;

  vec_t vecs[NVEC];

  display_decoder dut (
    .clk(clk), .reset(reset), .start(start),
    .digito0(digito0), .digito1(digito1), .digito2(digito2),
    .valor(valor), .busy(busy), .done(done), .erro(erro)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input int act, input int exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Start one conversion, wait (bounded) for done, check latency and result.
  task automatic run_conv(input string nm, input logic [6:0] d2, input logic [6:0] d1,
                          input logic [6:0] d0, input logic [9:0] ev, input logic ee,
                          input int edge_idx);
    int n;
    @(negedge clk);
    digito2 = d2; digito1 = d1; digito0 = d0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    // Scramble inputs after capture; the result must not depend on them.
    digito2 = SX; digito1 = SB; digito0 = SB;
    chk({nm, " busy"}, int'(busy), 1);
    n = 0;
    while (!done && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    chk({nm, " latency"}, n, edge_idx);
    chk({nm, " valor"}, int'(valor), int'(ev));
    chk({nm, " erro"}, int'(erro), int'(ee));
    chk({nm, " busy@done"}, int'(busy), 0);
    @(posedge clk); #1;
    chk({nm, " done falls"}, int'(done), 0);
    chk({nm, " valor held"}, int'(valor), int'(ev));
  endtask

  initial begin
    vecs[0]  = '{S2, S3, S4, 10'd234, 1'b0, VALID_EDGE};
    vecs[1]  = '{SB, SB, S7, 10'd7,   1'b0, VALID_EDGE};
    vecs[2]  = '{S9, S9, S9, 10'd999, 1'b0, VALID_EDGE};
    vecs[3]  = '{S2, S3, SB, 10'd0,   1'b1, ERROR_EDGE};
    vecs[4]  = '{S2, SX, S4, 10'd0,   1'b1, ERROR_EDGE};
    vecs[5]  = '{S1, SB, S0, 10'd0,   1'b1, ERROR_EDGE};
    vecs[6]  = '{S0, S4, S2, 10'd42,  1'b0, VALID_EDGE};
    vecs[7]  = '{S0, S0, S0, 10'd0,   1'b0, VALID_EDGE};
    vecs[8]  = '{SB, S0, S5, 10'd5,   1'b0, VALID_EDGE};
    vecs[9]  = '{SB, SB, SB, 10'd0,   1'b1, ERROR_EDGE};
    vecs[10] = '{S8, S6, S1, 10'd861, 1'b0, VALID_EDGE};
    vecs[11] = '{S1, S0, S0, 10'd100, 1'b0, VALID_EDGE};

    // Reset state.
    repeat (3) @(posedge clk);
    #1;
    chk("reset valor", int'(valor), 0);
    chk("reset busy", int'(busy), 0);
    chk("reset done", int'(done), 0);
    chk("reset erro", int'(erro), 0);
    @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < NVEC; i++)
      run_conv($sformatf("vec%0d", i), vecs[i].d2, vecs[i].d1, vecs[i].d0,
               vecs[i].v, vecs[i].e, vecs[i].edge_idx);

    // An error conversion after a valid one must clear valor and raise erro.
    run_conv("err after valid", S3, SB, S3, 10'd0, 1'b1, ERROR_EDGE);
    run_conv("valid after err", SB, S1, S2, 10'd12, 1'b0, VALID_EDGE);

    // Abort "999" during the 5th SHIFT cycle with reset; valor is nonzero beforehand.
    @(negedge clk);
    digito2 = S9; digito1 = S9; digito0 = S9; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (5) @(posedge clk);
    #3;
    chk("abort busy before", int'(busy), 1);
    reset = 1'b1;
    #1;
    chk("abort valor", int'(valor), 0);
    chk("abort busy", int'(busy), 0);
    chk("abort done", int'(done), 0);
    chk("abort erro", int'(erro), 0);
    @(negedge clk);
    reset = 1'b0;
    begin
      int seen;
      seen = 0;
      repeat (14) begin
        @(posedge clk); #1;
        if (done || busy) seen++;
      end
      chk("abort no done", seen, 0);
    end
    run_conv("after abort", S1, S0, S0, 10'd100, 1'b0, VALID_EDGE);

    // "042" at edge 0; start re-pulsed with "555" at edges 3 and 12 (ignored)
    // and at edge 13 (accepted, done at edge 24).
    @(negedge clk);
    digito2 = S0; digito1 = S4; digito0 = S2; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int e = 1; e <= 27; e++) begin
      @(negedge clk);
      if (e >= 3) begin
        digito2 = S5; digito1 = S5; digito0 = S5;
      end
      start = (e == 3) || (e == 12) || (e == 13);
      @(posedge clk); #1;
      chk($sformatf("b2b done edge%0d", e), int'(done), int'(e == 11 || e == 24));
      if (e == 11) chk("b2b valor 42", int'(valor), 42);
      if (e == 12) chk("b2b idle busy", int'(busy), 0);
      if (e == 13) chk("b2b accept busy", int'(busy), 1);
      if (e == 24) chk("b2b valor 555", int'(valor), 555);
    end
    start = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/display_decoder.md
# display_decoder

Sequential inverse of the three-digit 7-segment display driver: accepts three active-low 7-segment patterns, as the display path drives them, and recovers the 10-bit binary value they show. Each pattern is decoded to a BCD digit, and the leading-blank rules are checked. The result is then converted to binary by reverse double-dabble, one bit per clock. It sits in the self-check/loopback path, comparing displayed values against the source counter, under a start/busy/done handshake.

## Interface
- Parameters: none.
- clk  in  1  system clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-high; clears all state and outputs immediately.
- start  in  1  request conversion; sampled only in IDLE.
- digito0  in  7  ones-digit pattern, active-low, bit0=a … bit6=g.
- digito1  in  7  tens-digit pattern.
- digito2  in  7  hundreds-digit pattern.
- valor  out  10  converted binary value (0–999), registered.
- busy  out  1  high in DECODE and SHIFT.
- done  out  1  one-cycle completion pulse.
- erro  out  1  registered; valid with done, held until next done.

## Operation
- Pattern map (bit6..bit0): 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000.
- Blank is 1111111 and decodes to digit 0.
- Any other pattern is invalid.
- Blank rules:
  - digito2 may be blank.
  - digito1 may be blank only if digito2 is blank.
  - digito0 must never be blank.
  - 1000000 ("0") is always legal in any position, with no leading-zero check.
- Error condition: any invalid pattern or any blank-rule violation.
- FSM states: IDLE, DECODE, SHIFT, DONE.
  - IDLE: start=1 → DECODE; patterns are captured into registers on that edge.
  - DECODE: decode the captured patterns.
    - Error → DONE, with erro=1 and valor=0 loaded.
    - No error → load the 12-bit BCD register {hundreds, tens, ones}, clear the 10-bit binary shift register and the 4-bit counter, go to SHIFT.
  - SHIFT, per cycle:
    - Shift {bcd, bin} (22 bits) right by 1.
    - Then, for each BCD nibble ≥ 8, subtract 3 from that nibble.
    - Increment the counter.
    - On the 10th shift (counter was 9): load valor from the post-shift binary register, set erro=0, go to DONE.
  - DONE: done=1 for exactly one cycle → IDLE.
- start is ignored in DECODE, SHIFT and DONE. No queuing.
- Input patterns may change after the capture edge without affecting the result.
- valor and erro hold their last values until the next entry to DONE.
- Maximum result is 999 (0x3E7); no overflow is possible in 10 bits.

## Timing
- Reset values: valor=0, busy=0, done=0, erro=0, state IDLE, counter 0.
- Valid conversion, with edge 0 sampling start=1:
  - busy=1 after edges 0 through 10.
  - Edge 11 performs the last shift.
  - done=1 and valor/erro valid after edge 11; done falls after edge 12.
  - Latency is 12 cycles from the start sample to done.
- Error conversion: done=1 after edge 1, so latency is 2 cycles. busy=1 only for the DECODE cycle.
- Back-to-back: start asserted during the DONE cycle is ignored. The earliest new start is sampled on the edge after DONE. Throughput is one conversion per 13 cycles.
- Reset mid-operation, in any state:
  - All outputs go to reset values asynchronously, including valor=0, and the FSM returns to IDLE.
  - No done pulse is produced for the aborted conversion.
  - Release takes effect on the next edge, and start is honored on the first edge after release.

## Test plan
- digito2=0100100 ("2"), digito1=0110000 ("3"), digito0=0011001 ("4"), pulse start → done exactly 12 cycles later with valor=234 (0x0EA), erro=0.
- digito2=1111111, digito1=1111111, digito0=1111000 ("7") → valor=7, erro=0. Also 0010000 ×3 ("999") → valor=999 (0x3E7).
- digito0=1111111 (blank ones), other digits valid → done 2 cycles after start, erro=1, valor=0. Repeat with digito1=0101010 (invalid pattern), same response.
- digito2=1111001 ("1"), digito1=1111111, digito0=1000000 → erro=1 (blank tens under non-blank hundreds).
- Start "999", assert reset during the 5th SHIFT cycle → outputs 0 immediately, no done. After release, start "100" → valor=100, done after 12 cycles.
- Start "042", re-pulse start with "555" at cycles 3 and 12 (DONE) → both ignored, single done with valor=42. Start sampled at cycle 13 → valor=555.
